// File: rtl/dec_pkg.sv
// Shared types and encodings for the pipelined instruction decoder.
package dec_pkg;

  // Compact op code carried to the execute stage; OP_ILLEGAL must stay 0.
  typedef enum logic [5:0] {
    OP_ILLEGAL = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  // Major opcodes (inst[6:0]); all of them end in 2'b11.
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Which immediate format the op carries.
  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_SHAMT, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z
  } imm_type_t;

  // Per-entry control bits stored in the output queue.
  typedef struct packed {
    op_t  op;
    logic rs1_use;
    logic rs2_use;
    logic rd_we;
    logic illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/dec_core.sv
// Combinational RV32I(+M, +Zicsr) decoder: instruction -> op, operand flags, immediate.
module dec_core
  import dec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_M     = 1'b0,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic [31:0]     inst,
  output op_t             op,
  output logic            rs1_use,
  output logic            rs2_use,
  output logic            rd_we,
  output logic            illegal,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  op_t        op_raw;
  imm_type_t  imm_type;
  logic       rs1_raw;
  logic       rs2_raw;
  logic       we_raw;
  logic [31:0] imm32;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Classify the encoding; anything not matched (incl. inst[1:0]!=2'b11) stays OP_ILLEGAL.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    op_raw   = OP_ILLEGAL;
    imm_type = IMM_NONE;
    rs1_raw  = 1'b0;
    rs2_raw  = 1'b0;
    we_raw   = 1'b0;
    case (opcode)
      OPC_LUI:   begin op_raw = OP_LUI;   imm_type = IMM_U; we_raw = 1'b1; end
      OPC_AUIPC: begin op_raw = OP_AUIPC; imm_type = IMM_U; we_raw = 1'b1; end
      OPC_JAL:   begin op_raw = OP_JAL;   imm_type = IMM_J; we_raw = 1'b1; end
      OPC_JALR: begin
        imm_type = IMM_I; rs1_raw = 1'b1; we_raw = 1'b1;
        if (funct3 == 3'b000) op_raw = OP_JALR;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B; rs1_raw = 1'b1; rs2_raw = 1'b1;
        case (funct3)
          3'b000:  op_raw = OP_BEQ;
          3'b001:  op_raw = OP_BNE;
          3'b100:  op_raw = OP_BLT;
          3'b101:  op_raw = OP_BGE;
          3'b110:  op_raw = OP_BLTU;
          3'b111:  op_raw = OP_BGEU;
          default: ;
        endcase
      end
      OPC_LOAD: begin
        imm_type = IMM_I; rs1_raw = 1'b1; we_raw = 1'b1;
        case (funct3)
          3'b000:  op_raw = OP_LB;
          3'b001:  op_raw = OP_LH;
          3'b010:  op_raw = OP_LW;
          3'b100:  op_raw = OP_LBU;
          3'b101:  op_raw = OP_LHU;
          default: ;
        endcase
      end
      OPC_STORE: begin
        imm_type = IMM_S; rs1_raw = 1'b1; rs2_raw = 1'b1;
        case (funct3)
          3'b000:  op_raw = OP_SB;
          3'b001:  op_raw = OP_SH;
          3'b010:  op_raw = OP_SW;
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I; rs1_raw = 1'b1; we_raw = 1'b1;
        case (funct3)
          3'b000: op_raw = OP_ADDI;
          3'b010: op_raw = OP_SLTI;
          3'b011: op_raw = OP_SLTIU;
          3'b100: op_raw = OP_XORI;
          3'b110: op_raw = OP_ORI;
          3'b111: op_raw = OP_ANDI;
          3'b001: begin
            imm_type = IMM_SHAMT;
            if (funct7 == 7'b0000000) op_raw = OP_SLLI;
          end
          default: begin  // 3'b101
            imm_type = IMM_SHAMT;
            if (funct7 == 7'b0000000)      op_raw = OP_SRLI;
            else if (funct7 == 7'b0100000) op_raw = OP_SRAI;
          end
        endcase
      end
      OPC_OP: begin
        rs1_raw = 1'b1; rs2_raw = 1'b1; we_raw = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000: op_raw = OP_ADD;
              3'b001: op_raw = OP_SLL;
              3'b010: op_raw = OP_SLT;
              3'b011: op_raw = OP_SLTU;
              3'b100: op_raw = OP_XOR;
              3'b101: op_raw = OP_SRL;
              3'b110: op_raw = OP_OR;
              default: op_raw = OP_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      op_raw = OP_SUB;
            else if (funct3 == 3'b101) op_raw = OP_SRA;
          end
          7'b0000001: begin
            if (EN_M) begin
              case (funct3)
                3'b000: op_raw = OP_MUL;
                3'b001: op_raw = OP_MULH;
                3'b010: op_raw = OP_MULHSU;
                3'b011: op_raw = OP_MULHU;
                3'b100: op_raw = OP_DIV;
                3'b101: op_raw = OP_DIVU;
                3'b110: op_raw = OP_REM;
                default: op_raw = OP_REMU;
              endcase
            end
          end
          default: ;
        endcase
      end
      OPC_MISC_MEM: begin
        // fm/pred/succ are deliberately not inspected.
        if (funct3 == 3'b000) op_raw = OP_FENCE;
        else if (funct3 == 3'b001) begin op_raw = OP_FENCE_I; rs1_raw = 1'b1; end
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          if (inst[31:7] == 25'd0)                   op_raw = OP_ECALL;
          else if (inst[31:7] == {12'h001, 13'h0000}) op_raw = OP_EBREAK;
        end else if (EN_ZICSR && (funct3 != 3'b100)) begin
          we_raw = 1'b1;
          if (funct3[2]) begin
            imm_type = IMM_Z;
            case (funct3[1:0])
              2'b01:   op_raw = OP_CSRRWI;
              2'b10:   op_raw = OP_CSRRSI;
              default: op_raw = OP_CSRRCI;
            endcase
          end else begin
            rs1_raw = 1'b1;
            case (funct3[1:0])
              2'b01:   op_raw = OP_CSRRW;
              2'b10:   op_raw = OP_CSRRS;
              default: op_raw = OP_CSRRC;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  // An illegal encoding suppresses all side effects so a trap sees a clean entry.
  assign op      = op_raw;
  assign illegal = (op_raw == OP_ILLEGAL);
  assign rs1_use = rs1_raw && !illegal;
  assign rs2_use = rs2_raw && !illegal;
  assign rd_we   = we_raw && !illegal && (inst[11:7] != 5'd0);

  // Assemble the 32-bit immediate for the selected format.
  always_comb begin
    imm32 = 32'd0;
    if (!illegal) begin
      case (imm_type)
        IMM_I:     imm32 = {{20{inst[31]}}, inst[31:20]};
        IMM_SHAMT: imm32 = {27'd0, inst[24:20]};
        IMM_S:     imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        IMM_B:     imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        IMM_U:     imm32 = {inst[31:12], 12'd0};
        IMM_J:     imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        IMM_Z:     imm32 = {27'd0, inst[19:15]};
        default:   imm32 = 32'd0;
      endcase
    end
  end

  // Zero-extended formats have bit 31 clear, so one sign extension serves all.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/dec_pipe.sv
// Decode stage: combinational decode registered into a QDEPTH-entry output queue.
module dec_pipe
  import dec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int QDEPTH   = 2,
  parameter bit EN_M     = 1'b0,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic            hclk,
  input  logic            hrst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output op_t             out_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rs1_use,
  output logic            out_rs2_use,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm,
  output logic [11:0]     out_csr,
  output logic            out_illegal,
  output logic [15:0]     illegal_cnt
);

  localparam int          AW    = $clog2(QDEPTH);
  localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

  op_t             dec_op;
  logic            dec_rs1_use;
  logic            dec_rs2_use;
  logic            dec_rd_we;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  dec_ctrl_t       dec_ctrl;

  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] pc_q   [QDEPTH];
  logic [31:0]     inst_q [QDEPTH];
  logic [XLEN-1:0] imm_q  [QDEPTH];
  dec_ctrl_t       ctrl_q [QDEPTH];

  dec_ctrl_t       head_ctrl;

  dec_core #(.XLEN(XLEN), .EN_M(EN_M), .EN_ZICSR(EN_ZICSR)) u_core (
    .inst    (in_inst),
    .op      (dec_op),
    .rs1_use (dec_rs1_use),
    .rs2_use (dec_rs2_use),
    .rd_we   (dec_rd_we),
    .illegal (dec_illegal),
    .imm     (dec_imm)
  );

  assign dec_ctrl  = '{op: dec_op, rs1_use: dec_rs1_use, rs2_use: dec_rs2_use,
                       rd_we: dec_rd_we, illegal: dec_illegal};

  // Handshake: no bypass when full; flush cancels both transfers.
  assign in_ready  = (count != QFULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Queue pointers and occupancy.
  always_ff @(posedge hclk or posedge hrst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (hrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Queue storage written on push.
  // NOTE: storage has no reset; heads are masked while empty, so stale contents never leak out.
  always_ff @(posedge hclk) begin
    if (push) begin
      pc_q[wptr]   <= in_pc;
      inst_q[wptr] <= in_inst;
      imm_q[wptr]  <= dec_imm;
      ctrl_q[wptr] <= dec_ctrl;
    end
  end

  // Saturating count of illegal entries actually enqueued.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      illegal_cnt <= '0;
    end else if (push && dec_illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

  // Head view: storage at the read pointer, forced to zero while empty.
  assign head_ctrl   = out_valid ? ctrl_q[rptr] : '0;
  assign out_pc      = out_valid ? pc_q[rptr]   : '0;
  assign out_inst    = out_valid ? inst_q[rptr] : '0;
  assign out_imm     = out_valid ? imm_q[rptr]  : '0;
  assign out_op      = head_ctrl.op;
  assign out_rs1_use = head_ctrl.rs1_use;
  assign out_rs2_use = head_ctrl.rs2_use;
  assign out_rd_we   = head_ctrl.rd_we;
  assign out_illegal = head_ctrl.illegal;
  assign out_rs1     = out_inst[19:15];
  assign out_rs2     = out_inst[24:20];
  assign out_rd      = out_inst[11:7];
  assign out_csr     = out_inst[31:20];

endmodule
